rs_age_multi: RTL and testbench
===============================

RS_AGE_MULTI -- requirements
Module: rs_age_multi

Interface
REQ-001 Parameter DEPTH, default `RS_DEPTH, entry count, legal values 2 or more.
REQ-002 Parameter ISSUE_W, default 2, issue port count, legal values 1..2.
REQ-003 Parameter N_WB, default 3, wakeup writeback bus count, legal values 1 or more.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 flush_i  input  1  full squash of every entry.
REQ-007 recover_i  input  1  partial squash, qualified by live_tag_i.
REQ-008 live_tag_i  input  ROB_DEPTH  bitmap of live ROB tags.
REQ-009 prf_valid_i  input  N_PHYS_REGS  current PRF ready bits.
REQ-010 insert_valid_i  input  1  enqueue request.
REQ-011 insert_entry_i  input  rs_entry_t  entry to enqueue.
REQ-012 ready_o  output  1  at least one free slot.
REQ-013 wb_i  input  N_WB x wb_pkt_t  wakeup buses.
REQ-014 issue_valid_o  output  ISSUE_W  per-port selection valid.
REQ-015 issue_entry_o  output  ISSUE_W x rs_entry_t  per-port selected entry; zero when the port is invalid.
REQ-016 issue_ready_i  input  ISSUE_W  per-port grant.
REQ-017 count_o  output  $clog2(DEPTH)+1  occupied entry count.

Function
REQ-018 Wakeup match SHALL be: wb.valid && wb.rd_used && wb.prd==preg && preg!=0. Matching operands SHALL set the ready bit at the clock edge and become issuable the next cycle.
REQ-019 An entry is ready when it is occupied and valid, and each used source is either ready or unused.
REQ-020 Port 0 SHALL select the oldest ready entry. Port 1 SHALL select the oldest ready entry other than port 0's selection. Age SHALL be enqueue order.
REQ-021 Held selections: if issue_valid_o[p] && !issue_ready_i[p], port p SHALL hold the same index until granted. A held index SHALL be excluded from the other port's fresh pick. A hold SHALL override a fresh pick even if an older entry has since become ready.
REQ-022 An entry SHALL be removed only when its port is granted. Simultaneous grants on both ports SHALL remove both entries in the same cycle.
REQ-023 Enqueue SHALL fire when insert_valid_i && ready_o and SHALL write the lowest-index free slot. ready_o and count_o SHALL reflect the pre-edge state; a slot freed in the same cycle is not reused until the next cycle.
REQ-024 On enqueue, each source's ready bit = incoming bit OR prf_valid_i[preg] OR any same-cycle wb_i match. preg 0 SHALL always be ready.
REQ-025 count_o next value = count + enqueue - number of grants, with no wrap. The count SHALL never exceed DEPTH.
REQ-026 Event priority: flush_i > recover_i > normal operation.
REQ-027 On flush_i, all entries and holds SHALL clear. issue_valid_o SHALL be 0 that cycle and grants SHALL be ignored.
REQ-028 On recover_i, entries whose live_tag_i[rob_tag] is 0 SHALL clear, along with any hold on them. Survivors SHALL still receive same-cycle wakeups and keep relative age. No enqueue SHALL occur. issue_valid_o SHALL be 0 that cycle.
REQ-029 With ISSUE_W=1, port 1 logic SHALL be absent. Behaviour is then single-port oldest-first with hold.

Reset
REQ-030 While rst_n=0 at the edge, all slots and holds SHALL clear and age state SHALL be zeroed.
REQ-031 Output values after reset: issue_valid_o=0, issue_entry_o=0, ready_o=1, count_o=0.
REQ-032 Reset asserted mid-hold SHALL drop the hold without issuing.

Configuration
REQ-033 Macro RS_AGE_SELECT_EN.
REQ-034 When RS_AGE_SELECT_EN is defined, selection is oldest-first as in REQ-020, using the age matrix.
REQ-035 When RS_AGE_SELECT_EN is undefined, port 0 picks the lowest-index ready entry and port 1 the next-lowest. No age state is built. All other requirements are unchanged.

Structure
REQ-036 The following SHALL come from package ooop_types: rs_entry_t, wb_pkt_t, PREG_W, ROB_DEPTH, N_PHYS_REGS. ISSUE_W and N_WB defaults SHALL be defined in ooop_defs.vh.
REQ-037 Sub-module rs_age_matrix (parameter DEPTH) SHALL hold an older[i][j] bit matrix.
- Inputs: alloc one-hot, dealloc mask, request mask.
- Output: one-hot oldest request.
- Instantiated twice for port 0 and port 1; the port 1 request mask excludes port 0's pick.

Verification
REQ-038 Insert A (tag 3) then B (tag 5), both ready, DEPTH=4, both grants held 0 -> port0=A and port1=B, both held stable. Assert both grants -> count_o goes 2 to 0.
REQ-039 Insert into slot 2, then slot 0 after slot 0 frees; both ready -> port0 picks slot 2 (older) with the macro, slot 0 without it.
REQ-040 Insert an entry whose prs1=7 is not ready while wb_i[1] writes prd 7 in the same cycle -> the entry issues the next cycle.
REQ-041 Hold on tag 4, recover_i with live_tag_i[4]=0 and [2]=1 -> tag 4 dropped, tag 2 survives, issue_valid_o=0 during the recover cycle.
REQ-042 Fill DEPTH entries -> ready_o=0 and insert is ignored. Grant one and insert in the same cycle -> count_o stays at DEPTH-1 and ready_o=1.
REQ-043 flush_i while port 0 is granted -> no removal is counted, count_o=0 the next cycle.

Source files
------------

// File: rtl/ooop_types.sv
//============================================================================
// Module      : ooop_types (package)
// Description : Shared types and sizes for the out-of-order core slice:
//               reservation-station entry, writeback wakeup packet, PRF and
//               ROB sizes. Also carries the build defaults for the RS depth,
//               issue width and writeback bus count (RS_DEPTH, OOOP_ISSUE_W,
//               OOOP_N_WB), each overridable from the command line.
// Revision    : 1.0 - initial release
//============================================================================
`ifndef RS_DEPTH
`define RS_DEPTH 4
`endif
`ifndef OOOP_ISSUE_W
`define OOOP_ISSUE_W 2
`endif
`ifndef OOOP_N_WB
`define OOOP_N_WB 3
`endif

`default_nettype none

package ooop_types;

    localparam int N_PHYS_REGS = 64;
    localparam int PREG_W      = $clog2(N_PHYS_REGS);
    localparam int ROB_DEPTH   = 16;
    localparam int ROB_TAG_W   = $clog2(ROB_DEPTH);

    // One reservation-station slot worth of micro-op state
    typedef struct packed {
        logic                 valid;
        logic [ROB_TAG_W-1:0] rob_tag;
        logic [7:0]           op;
        logic [PREG_W-1:0]    prs1;
        logic                 prs1_used;
        logic                 prs1_ready;
        logic [PREG_W-1:0]    prs2;
        logic                 prs2_used;
        logic                 prs2_ready;
        logic [PREG_W-1:0]    prd;
        logic                 rd_used;
    } rs_entry_t;

    // Result broadcast used to wake dependent sources
    typedef struct packed {
        logic              valid;
        logic              rd_used;
        logic [PREG_W-1:0] prd;
    } wb_pkt_t;

endpackage

`default_nettype wire

// File: rtl/rs_age_matrix.sv
//============================================================================
// Module      : rs_age_matrix
// Description : Relative-age tracker for DEPTH slots. older[i][j]=1 means
//               slot i was enqueued before slot j. Produces a one-hot of the
//               oldest requesting slot.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module rs_age_matrix #(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DEPTH-1:0] alloc_i,
    input  logic [DEPTH-1:0] dealloc_i,
    input  logic [DEPTH-1:0] req_i,
    output logic [DEPTH-1:0] oldest_o
);

    logic [DEPTH-1:0][DEPTH-1:0] r_older;

    // A new slot is younger than everything: clear its row, set its column
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_older <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (alloc_i[i]) begin
                        r_older[i][j] <= 1'b0;
                    end else if (alloc_i[j] && (i != j)) begin
                        r_older[i][j] <= 1'b1;
                    end else if (dealloc_i[i] || dealloc_i[j]) begin
                        r_older[i][j] <= 1'b0;
                    end
                end
            end
        end
    end

    // A requester wins when no other requester is older than it
    always_comb begin
        oldest_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            oldest_o[i] = req_i[i];
            for (int j = 0; j < DEPTH; j++) begin
                if ((j != i) && req_i[j] && r_older[j][i]) begin
                    oldest_o[i] = 1'b0;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rs_age_multi.sv
//============================================================================
// Module      : rs_age_multi
// Description : Multi-issue reservation station with wakeup, per-port
//               selection holding, flush and ROB-tag based recovery.
//               Build option RS_AGE_SELECT_EN: when defined, each port picks
//               the oldest ready entry via rs_age_matrix; when undefined,
//               ports pick by lowest slot index and no age state exists.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module rs_age_multi
    import ooop_types::*;
#(
    parameter int DEPTH   = `RS_DEPTH,
    parameter int ISSUE_W = `OOOP_ISSUE_W,
    parameter int N_WB    = `OOOP_N_WB
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush_i,
    input  logic                    recover_i,
    input  logic [ROB_DEPTH-1:0]    live_tag_i,
    input  logic [N_PHYS_REGS-1:0]  prf_valid_i,
    input  logic                    insert_valid_i,
    input  rs_entry_t               insert_entry_i,
    output logic                    ready_o,
    input  wb_pkt_t                 wb_i [N_WB],
    output logic [ISSUE_W-1:0]      issue_valid_o,
    output rs_entry_t               issue_entry_o [ISSUE_W],
    input  logic [ISSUE_W-1:0]      issue_ready_i,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int c_IDX_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0]   r_occ;
    rs_entry_t          r_ent      [DEPTH];
    logic [ISSUE_W-1:0] r_hold_vld;
    logic [c_IDX_W-1:0] r_hold_idx [ISSUE_W];

    rs_entry_t          w_woke     [DEPTH];
    rs_entry_t          w_ins;
    logic [DEPTH-1:0]   w_rdy;
    logic [DEPTH-1:0]   w_live;
    logic [DEPTH-1:0]   w_alloc_oh;
    logic [DEPTH-1:0]   w_grant_oh;
    logic [DEPTH-1:0]   w_excl0;
    logic [DEPTH-1:0]   w_hold_oh  [ISSUE_W];
    logic [DEPTH-1:0]   w_req      [ISSUE_W];
    logic [DEPTH-1:0]   w_pick     [ISSUE_W];
    logic [DEPTH-1:0]   w_sel_oh   [ISSUE_W];
    logic [c_IDX_W-1:0] w_sel_idx  [ISSUE_W];
    logic               w_quiet;
    logic               w_enq;

    // A source is woken by any valid writeback of a real destination register
    function automatic logic wb_hit(input logic [PREG_W-1:0] preg);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < N_WB; k++) begin
            if (wb_i[k].valid && wb_i[k].rd_used && (wb_i[k].prd == preg) && (preg != '0)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    assign w_quiet = flush_i || recover_i;

    // Per-slot readiness, ROB liveness and post-wakeup entry image
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_rdy[i]  = r_occ[i] && r_ent[i].valid &&
                        (!r_ent[i].prs1_used || r_ent[i].prs1_ready) &&
                        (!r_ent[i].prs2_used || r_ent[i].prs2_ready);
            w_live[i] = live_tag_i[r_ent[i].rob_tag];
            w_woke[i] = r_ent[i];
            w_woke[i].prs1_ready = r_ent[i].prs1_ready | wb_hit(r_ent[i].prs1);
            w_woke[i].prs2_ready = r_ent[i].prs2_ready | wb_hit(r_ent[i].prs2);
        end
    end

    // One-hot view of each port's held slot
    always_comb begin
        for (int p = 0; p < ISSUE_W; p++) begin
            w_hold_oh[p] = '0;
            if (r_hold_vld[p]) begin
                w_hold_oh[p][r_hold_idx[p]] = 1'b1;
            end
        end
    end

    // Port 0's fresh pick must skip whatever port 1 is holding
    generate
        if (ISSUE_W > 1) begin : g_excl_hold1
            assign w_excl0 = w_hold_oh[ISSUE_W-1];
        end else begin : g_excl_none
            assign w_excl0 = '0;
        end
    endgenerate

`ifdef RS_AGE_SELECT_EN
    logic [DEPTH-1:0] w_dealloc;

    // Slots leaving the station this edge, for age bookkeeping
    always_comb begin
        if (flush_i) begin
            w_dealloc = '1;
        end else if (recover_i) begin
            w_dealloc = r_occ & ~w_live;
        end else begin
            w_dealloc = w_grant_oh;
        end
    end
`endif

    generate
        for (genvar p = 0; p < ISSUE_W; p++) begin : g_port
            if (p == 0) begin : g_req_first
                assign w_req[p] = w_rdy & ~w_excl0;
            end else begin : g_req_second
                assign w_req[p] = w_rdy & ~w_sel_oh[0];
            end
`ifdef RS_AGE_SELECT_EN
            rs_age_matrix #(
                .DEPTH (DEPTH)
            ) u_age (
                .clk       (clk),
                .rst_n     (rst_n),
                .alloc_i   (w_alloc_oh),
                .dealloc_i (w_dealloc),
                .req_i     (w_req[p]),
                .oldest_o  (w_pick[p])
            );
`else
            assign w_pick[p] = w_req[p] & (-w_req[p]);
`endif
            assign w_sel_oh[p]      = r_hold_vld[p] ? w_hold_oh[p] : w_pick[p];
            assign issue_valid_o[p] = (|w_sel_oh[p]) && !w_quiet;
        end
    endgenerate

    // Selected slot index, issued entry and granted slot mask
    always_comb begin
        w_grant_oh = '0;
        for (int p = 0; p < ISSUE_W; p++) begin
            w_sel_idx[p] = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (w_sel_oh[p][i]) begin
                    w_sel_idx[p] = c_IDX_W'(i);
                end
            end
            issue_entry_o[p] = issue_valid_o[p] ? r_ent[w_sel_idx[p]] : '0;
            if (issue_valid_o[p] && issue_ready_i[p]) begin
                w_grant_oh = w_grant_oh | w_sel_oh[p];
            end
        end
    end

    // Occupancy, lowest free slot and the incoming entry's ready bits
    always_comb begin
        logic found;
        found      = 1'b0;
        count_o    = '0;
        w_alloc_oh = '0;
        ready_o    = ~&r_occ;
        w_enq      = insert_valid_i && ready_o && !w_quiet;
        for (int i = 0; i < DEPTH; i++) begin
            count_o = count_o + c_CNT_W'(r_occ[i]);
            if (!found && !r_occ[i]) begin
                found         = 1'b1;
                w_alloc_oh[i] = w_enq;
            end
        end
        w_ins = insert_entry_i;
        w_ins.prs1_ready = insert_entry_i.prs1_ready | prf_valid_i[insert_entry_i.prs1] |
                           wb_hit(insert_entry_i.prs1) | (insert_entry_i.prs1 == '0);
        w_ins.prs2_ready = insert_entry_i.prs2_ready | prf_valid_i[insert_entry_i.prs2] |
                           wb_hit(insert_entry_i.prs2) | (insert_entry_i.prs2 == '0);
    end

    // Slot, entry and hold state; flush beats recover beats normal flow
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_occ      <= '0;
            r_hold_vld <= '0;
            for (int p = 0; p < ISSUE_W; p++) begin
                r_hold_idx[p] <= '0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= '0;
            end
        end else if (flush_i) begin
            r_occ      <= '0;
            r_hold_vld <= '0;
        end else if (recover_i) begin
            r_occ <= r_occ & w_live;
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= w_woke[i];
            end
            for (int p = 0; p < ISSUE_W; p++) begin
                r_hold_vld[p] <= r_hold_vld[p] && w_live[r_hold_idx[p]];
            end
        end else begin
            r_occ <= (r_occ & ~w_grant_oh) | w_alloc_oh;
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= w_alloc_oh[i] ? w_ins : w_woke[i];
            end
            for (int p = 0; p < ISSUE_W; p++) begin
                r_hold_vld[p] <= issue_valid_o[p] && !issue_ready_i[p];
                r_hold_idx[p] <= w_sel_idx[p];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rs_age_multi.sv
`default_nettype none

module tb_rs_age_multi;
    import ooop_types::*;

    localparam int DEPTH   = 4;
    localparam int ISSUE_W = 2;
    localparam int N_WB    = 3;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   flush_i, recover_i, insert_valid_i;
    logic [ROB_DEPTH-1:0]   live_tag_i;
    logic [N_PHYS_REGS-1:0] prf_valid_i;
    rs_entry_t              insert_entry_i;
    logic                   ready_o;
    wb_pkt_t                wb_i [N_WB];
    logic [ISSUE_W-1:0]     issue_valid_o, issue_ready_i;
    rs_entry_t              issue_entry_o [ISSUE_W];
    logic [$clog2(DEPTH):0] count_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rs_age_multi #(.DEPTH(DEPTH), .ISSUE_W(ISSUE_W), .N_WB(N_WB)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .recover_i(recover_i),
        .live_tag_i(live_tag_i), .prf_valid_i(prf_valid_i),
        .insert_valid_i(insert_valid_i), .insert_entry_i(insert_entry_i),
        .ready_o(ready_o), .wb_i(wb_i), .issue_valid_o(issue_valid_o),
        .issue_entry_o(issue_entry_o), .issue_ready_i(issue_ready_i), .count_o(count_o)
    );

    // ---------------- reference model: slots with enqueue sequence numbers
    bit        m_occ  [DEPTH];
    rs_entry_t m_ent  [DEPTH];
    int        m_seq  [DEPTH];
    int        m_next_seq;
    bit        m_hold [ISSUE_W];
    int        m_hidx [ISSUE_W];
    bit        e_valid[ISSUE_W];
    int        e_idx  [ISSUE_W];
    bit        e_ready;
    int        e_count;

    function automatic bit m_wb_hit(logic [PREG_W-1:0] r);
        if (r == 0) return 1'b0;
        for (int k = 0; k < N_WB; k++)
            if (wb_i[k].valid && wb_i[k].rd_used && wb_i[k].prd == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_issuable(int i);
        return m_occ[i] && m_ent[i].valid &&
               (!m_ent[i].prs1_used || m_ent[i].prs1_ready) &&
               (!m_ent[i].prs2_used || m_ent[i].prs2_ready);
    endfunction

    function automatic int m_pick(int excl);
        int best = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (i != excl && m_issuable(i)) begin
`ifdef RS_AGE_SELECT_EN
                if (best < 0 || m_seq[i] < m_seq[best]) best = i;
`else
                if (best < 0) best = i;
`endif
            end
        end
        return best;
    endfunction

    task automatic model_outputs();
        int s0, s1;
        e_count = 0;
        for (int i = 0; i < DEPTH; i++) if (m_occ[i]) e_count++;
        e_ready = (e_count < DEPTH);
        s0 = m_hold[0] ? m_hidx[0] : m_pick(m_hold[1] ? m_hidx[1] : -1);
        s1 = m_hold[1] ? m_hidx[1] : m_pick(s0);
        e_valid[0] = (s0 >= 0) && !flush_i && !recover_i;
        e_valid[1] = (s1 >= 0) && !flush_i && !recover_i;
        e_idx[0] = s0;
        e_idx[1] = s1;
    endtask

    task automatic model_update();
        bit pre_occ [DEPTH];
        int fs;
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) m_occ[i] = 0;
            for (int p = 0; p < ISSUE_W; p++) m_hold[p] = 0;
            m_next_seq = 0;
            return;
        end
        if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) m_occ[i] = 0;
            for (int p = 0; p < ISSUE_W; p++) m_hold[p] = 0;
            return;
        end
        pre_occ = m_occ;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_occ[i]) begin
                if (m_wb_hit(m_ent[i].prs1)) m_ent[i].prs1_ready = 1'b1;
                if (m_wb_hit(m_ent[i].prs2)) m_ent[i].prs2_ready = 1'b1;
            end
        end
        if (recover_i) begin
            for (int i = 0; i < DEPTH; i++)
                if (m_occ[i] && !live_tag_i[m_ent[i].rob_tag]) m_occ[i] = 0;
            for (int p = 0; p < ISSUE_W; p++)
                if (m_hold[p] && !m_occ[m_hidx[p]]) m_hold[p] = 0;
            return;
        end
        for (int p = 0; p < ISSUE_W; p++) begin
            if (e_valid[p] && issue_ready_i[p]) m_occ[e_idx[p]] = 0;
            m_hold[p] = e_valid[p] && !issue_ready_i[p];
            m_hidx[p] = e_idx[p];
        end
        if (insert_valid_i && e_ready) begin
            fs = -1;
            for (int i = 0; i < DEPTH; i++) if (!pre_occ[i] && fs < 0) fs = i;
            m_ent[fs] = insert_entry_i;
            m_ent[fs].prs1_ready = insert_entry_i.prs1_ready || prf_valid_i[insert_entry_i.prs1] ||
                                   m_wb_hit(insert_entry_i.prs1) || insert_entry_i.prs1 == 0;
            m_ent[fs].prs2_ready = insert_entry_i.prs2_ready || prf_valid_i[insert_entry_i.prs2] ||
                                   m_wb_hit(insert_entry_i.prs2) || insert_entry_i.prs2 == 0;
            m_occ[fs] = 1;
            m_seq[fs] = m_next_seq++;
        end
    endtask

    // ---------------- stimulus helpers
    task automatic tick();
        model_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        flush_i = 0; recover_i = 0; insert_valid_i = 0; issue_ready_i = '0;
        live_tag_i = '1; prf_valid_i = '0; insert_entry_i = '0;
        for (int k = 0; k < N_WB; k++) wb_i[k] = '0;
    endtask

    function automatic rs_entry_t mk(int tag, int p1, bit u1);
        rs_entry_t e = '0;
        e.valid = 1'b1; e.rob_tag = 4'(tag); e.op = 8'(tag * 3 + 1);
        e.prs1 = 6'(p1); e.prs1_used = u1; e.prd = 6'(tag + 20); e.rd_used = 1'b1;
        return e;
    endfunction

    function automatic rs_entry_t rand_entry();
        rs_entry_t e;
        e.valid = 1'b1; e.rob_tag = 4'($urandom_range(0, 15)); e.op = 8'($urandom);
        e.prs1 = 6'($urandom_range(0, 15)); e.prs1_used = 1'($urandom); e.prs1_ready = ($urandom_range(0, 3) == 0);
        e.prs2 = 6'($urandom_range(0, 15)); e.prs2_used = 1'($urandom); e.prs2_ready = ($urandom_range(0, 3) == 0);
        e.prd = 6'($urandom_range(1, 15)); e.rd_used = 1'($urandom);
        return e;
    endfunction

    // ---------------- scenarios
    task automatic test_reset();
        idle(); rst_n = 0; tick(); tick(); rst_n = 1; #2;
        n_cmp++; if (issue_valid_o !== 2'b00) begin n_err++; $display("FAIL reset_valid: got %b want 00", issue_valid_o); end
        n_cmp++; if (issue_entry_o[0] !== '0) begin n_err++; $display("FAIL reset_entry0: got %h want 0", issue_entry_o[0]); end
        n_cmp++; if (issue_entry_o[1] !== '0) begin n_err++; $display("FAIL reset_entry1: got %h want 0", issue_entry_o[1]); end
        n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", ready_o); end
        n_cmp++; if (count_o !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count_o); end
    endtask

    task automatic test_two_port();
        idle(); insert_valid_i = 1; insert_entry_i = mk(3, 0, 0); tick();
        insert_entry_i = mk(5, 0, 0); tick();
        idle(); #2;
        for (int r = 0; r < 2; r++) begin
            n_cmp++; if (issue_valid_o !== 2'b11) begin n_err++; $display("FAIL two_port_valid[%0d]: got %b want 11", r, issue_valid_o); end
            n_cmp++; if (issue_entry_o[0].rob_tag !== 4'd3) begin n_err++; $display("FAIL two_port_p0[%0d]: got tag %0d want 3", r, issue_entry_o[0].rob_tag); end
            n_cmp++; if (issue_entry_o[1].rob_tag !== 4'd5) begin n_err++; $display("FAIL two_port_p1[%0d]: got tag %0d want 5", r, issue_entry_o[1].rob_tag); end
            tick(); #2;
        end
        n_cmp++; if (count_o !== 3'd2) begin n_err++; $display("FAIL two_port_count_before: got %0d want 2", count_o); end
        issue_ready_i = 2'b11; tick(); idle(); #2;
        n_cmp++; if (count_o !== 3'd0) begin n_err++; $display("FAIL two_port_count_after: got %0d want 0", count_o); end
        n_cmp++; if (issue_valid_o !== 2'b00) begin n_err++; $display("FAIL two_port_empty_valid: got %b want 00", issue_valid_o); end
    endtask

    task automatic test_age();
        logic [3:0] want0, want1;
        idle(); insert_valid_i = 1; insert_entry_i = mk(1, 0, 0); tick();
        insert_entry_i = mk(2, 0, 0); tick();
        insert_entry_i = mk(6, 9, 1); tick();
        idle(); issue_ready_i = 2'b11; tick();
        idle(); insert_valid_i = 1; insert_entry_i = mk(7, 0, 0); wb_i[0] = '{valid: 1'b1, rd_used: 1'b1, prd: 6'd9}; tick();
        idle(); #2;
`ifdef RS_AGE_SELECT_EN
        want0 = 4'd6; want1 = 4'd7;
`else
        want0 = 4'd7; want1 = 4'd6;
`endif
        n_cmp++; if (issue_valid_o !== 2'b11) begin n_err++; $display("FAIL age_valid: got %b want 11", issue_valid_o); end
        n_cmp++; if (issue_entry_o[0].rob_tag !== want0) begin n_err++; $display("FAIL age_p0: got tag %0d want %0d", issue_entry_o[0].rob_tag, want0); end
        n_cmp++; if (issue_entry_o[1].rob_tag !== want1) begin n_err++; $display("FAIL age_p1: got tag %0d want %0d", issue_entry_o[1].rob_tag, want1); end
        issue_ready_i = 2'b11; tick(); idle();
    endtask

    task automatic test_bypass();
        idle(); insert_valid_i = 1; insert_entry_i = mk(8, 7, 1);
        wb_i[1] = '{valid: 1'b1, rd_used: 1'b1, prd: 6'd7}; tick();
        idle(); #2;
        n_cmp++; if (issue_valid_o[0] !== 1'b1) begin n_err++; $display("FAIL bypass_valid: got %b want 1", issue_valid_o[0]); end
        n_cmp++; if (issue_entry_o[0].rob_tag !== 4'd8) begin n_err++; $display("FAIL bypass_tag: got %0d want 8", issue_entry_o[0].rob_tag); end
        n_cmp++; if (issue_entry_o[0].prs1_ready !== 1'b1) begin n_err++; $display("FAIL bypass_rdybit: got %b want 1", issue_entry_o[0].prs1_ready); end
        issue_ready_i = 2'b01; insert_valid_i = 1; insert_entry_i = mk(9, 12, 1);
        wb_i[2] = '{valid: 1'b1, rd_used: 1'b0, prd: 6'd12}; tick();
        idle(); #2;
        n_cmp++; if (issue_valid_o !== 2'b00) begin n_err++; $display("FAIL bypass_no_rd_used: got %b want 00", issue_valid_o); end
        n_cmp++; if (count_o !== 3'd1) begin n_err++; $display("FAIL bypass_count: got %0d want 1", count_o); end
        wb_i[0] = '{valid: 1'b1, rd_used: 1'b1, prd: 6'd12}; tick();
        idle(); #2;
        n_cmp++; if (issue_valid_o[0] !== 1'b1 || issue_entry_o[0].rob_tag !== 4'd9) begin n_err++; $display("FAIL bypass_late_wake: got v=%b tag %0d want v=1 tag 9", issue_valid_o[0], issue_entry_o[0].rob_tag); end
        issue_ready_i = 2'b01; tick(); idle();
    endtask

    task automatic test_recover();
        idle(); insert_valid_i = 1; insert_entry_i = mk(4, 0, 0); tick();
        insert_entry_i = mk(2, 0, 0); tick();
        idle(); tick(); #2;
        n_cmp++; if (issue_valid_o !== 2'b11 || issue_entry_o[0].rob_tag !== 4'd4) begin n_err++; $display("FAIL recover_pre: got v=%b tag %0d want v=11 tag 4", issue_valid_o, issue_entry_o[0].rob_tag); end
        recover_i = 1; live_tag_i = '1; live_tag_i[4] = 1'b0; issue_ready_i = 2'b11; #2;
        n_cmp++; if (issue_valid_o !== 2'b00) begin n_err++; $display("FAIL recover_quiet: got %b want 00", issue_valid_o); end
        tick(); idle(); #2;
        n_cmp++; if (count_o !== 3'd1) begin n_err++; $display("FAIL recover_count: got %0d want 1", count_o); end
        n_cmp++; if (issue_valid_o !== 2'b10) begin n_err++; $display("FAIL recover_hold_valid: got %b want 10", issue_valid_o); end
        n_cmp++; if (issue_entry_o[1].rob_tag !== 4'd2) begin n_err++; $display("FAIL recover_survivor: got tag %0d want 2", issue_entry_o[1].rob_tag); end
        issue_ready_i = 2'b10; tick(); idle(); #2;
        n_cmp++; if (count_o !== 3'd0) begin n_err++; $display("FAIL recover_drain: got %0d want 0", count_o); end
    endtask

    task automatic test_full();
        idle(); insert_valid_i = 1;
        for (int t = 0; t < DEPTH; t++) begin insert_entry_i = mk(10 + t, 0, 0); tick(); end
        #2;
        n_cmp++; if (ready_o !== 1'b0 || count_o !== 3'd4) begin n_err++; $display("FAIL full_state: got ready=%b count=%0d want ready=0 count=4", ready_o, count_o); end
        insert_entry_i = mk(14, 0, 0); tick(); #2;
        n_cmp++; if (count_o !== 3'd4) begin n_err++; $display("FAIL full_ignore: got %0d want 4", count_o); end
        insert_entry_i = mk(15, 0, 0); issue_ready_i = 2'b01; tick(); idle(); #2;
        n_cmp++; if (count_o !== 3'd3 || ready_o !== 1'b1) begin n_err++; $display("FAIL full_grant_insert: got count=%0d ready=%b want count=3 ready=1", count_o, ready_o); end
        issue_ready_i = 2'b11;
        for (int t = 0; t < 4; t++) tick();
        idle(); #2;
        n_cmp++; if (count_o !== 3'd0) begin n_err++; $display("FAIL full_drain: got %0d want 0", count_o); end
    endtask

    task automatic test_flush();
        idle(); insert_valid_i = 1; insert_entry_i = mk(1, 0, 0); tick();
        insert_entry_i = mk(3, 0, 0); tick();
        idle(); issue_ready_i = 2'b01; flush_i = 1; #2;
        n_cmp++; if (issue_valid_o !== 2'b00) begin n_err++; $display("FAIL flush_quiet: got %b want 00", issue_valid_o); end
        tick(); idle(); #2;
        n_cmp++; if (count_o !== 3'd0 || ready_o !== 1'b1) begin n_err++; $display("FAIL flush_count: got count=%0d ready=%b want 0/1", count_o, ready_o); end
    endtask

    task automatic test_reset_hold();
        idle(); insert_valid_i = 1; insert_entry_i = mk(6, 0, 0); tick();
        idle(); tick();
        rst_n = 0; tick(); rst_n = 1; #2;
        n_cmp++; if (issue_valid_o !== 2'b00 || count_o !== 3'd0) begin n_err++; $display("FAIL reset_hold: got v=%b count=%0d want 00/0", issue_valid_o, count_o); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            idle();
            flush_i        = ($urandom_range(0, 49) == 0);
            recover_i      = ($urandom_range(0, 19) == 0);
            live_tag_i     = 16'($urandom | $urandom);
            insert_valid_i = ($urandom_range(0, 9) < 6);
            insert_entry_i = rand_entry();
            issue_ready_i  = 2'($urandom);
            prf_valid_i[15:0] = 16'($urandom & $urandom & $urandom);
            for (int k = 0; k < N_WB; k++)
                wb_i[k] = '{valid: ($urandom_range(0, 9) < 4), rd_used: ($urandom_range(0, 9) < 8), prd: 6'($urandom_range(0, 15))};
            #2;
            model_outputs();
            n_cmp++; if (issue_valid_o !== {e_valid[1], e_valid[0]}) begin n_err++; $display("FAIL rand_valid @%0d: got %b want %b%b", c, issue_valid_o, e_valid[1], e_valid[0]); end
            for (int p = 0; p < ISSUE_W; p++) begin
                rs_entry_t want;
                want = e_valid[p] ? m_ent[e_idx[p]] : '0;
                n_cmp++; if (issue_entry_o[p] !== want) begin n_err++; $display("FAIL rand_entry%0d @%0d: got %h want %h", p, c, issue_entry_o[p], want); end
            end
            n_cmp++; if (ready_o !== e_ready) begin n_err++; $display("FAIL rand_ready @%0d: got %b want %b", c, ready_o, e_ready); end
            n_cmp++; if (count_o !== 3'(e_count)) begin n_err++; $display("FAIL rand_count @%0d: got %0d want %0d", c, count_o, e_count); end
            tick();
        end
        idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0;
        idle();
        test_reset();
        test_two_port();
        test_age();
        test_bypass();
        test_recover();
        test_full();
        test_flush();
        test_reset_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
